// File: rtl/mul_result.sv
// Purpose : multiply result select in Memory stage plus the E->M and M->W pipeline registers.
// Latency : op accepted in E at edge n -> MulResultM/MulValidM after edge n, MulResultW/MulValidW after edge n+1.
// Backpr. : StallM/StallW hold their stage; flush beats stall; a stalled M stage sends a bubble into W.
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   StallM, FlushM              hold / clear the E->M register
//   StallW, FlushW              hold / clear the M->W register
//   MulValidE, Funct3E, W64E    multiply op descriptor in Execute
//   ProdM                       double-width product from the multiplier, valid in M
//   MulResultM, MulValidM       selected result in M (forwarding path)
//   MulResultW, MulValidW       registered result in Writeback
module mul_result #(
  parameter int XLEN = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                StallM,
  input  logic                FlushM,
  input  logic                StallW,
  input  logic                FlushW,
  input  logic                MulValidE,
  input  logic [2:0]          Funct3E,
  input  logic                W64E,
  input  logic [2*XLEN-1:0]   ProdM,
  output logic [XLEN-1:0]     MulResultM,
  output logic                MulValidM,
  output logic [XLEN-1:0]     MulResultW,
  output logic                MulValidW
);

  // E->M pipeline register
  logic       valid_m_q, valid_m_d;
  logic [2:0] funct3_m_q, funct3_m_d;
  logic       w64_m_q, w64_m_d;

  // M->W pipeline register
  logic            valid_w_q, valid_w_d;
  logic [XLEN-1:0] result_w_q, result_w_d;

  // Word-width (MULW) result path; only exists for a 64-bit datapath.
  logic [XLEN-1:0] word_ext;
  logic            use_word;

  logic [XLEN-1:0] sel_res;
  logic            live_m;

  always_comb begin
    valid_m_d  = valid_m_q;
    funct3_m_d = funct3_m_q;
    w64_m_d    = w64_m_q;
    if (FlushM) begin
      valid_m_d  = 1'b0;
      funct3_m_d = 3'b000;
      w64_m_d    = 1'b0;
    end else if (!StallM) begin
      valid_m_d  = MulValidE;
      funct3_m_d = Funct3E;
      w64_m_d    = W64E;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_m_q  <= 1'b0;
      funct3_m_q <= 3'b000;
      w64_m_q    <= 1'b0;
    end else begin
      valid_m_q  <= valid_m_d;
      funct3_m_q <= funct3_m_d;
      w64_m_q    <= w64_m_d;
    end
  end

  generate
    if (XLEN == 64) begin : g_word
      assign word_ext = {{(XLEN-32){ProdM[31]}}, ProdM[31:0]};
      assign use_word = w64_m_q;
    end else begin : g_noword
      // 32-bit datapath: the W64 flag has no meaning and is dropped.
      assign word_ext = '0;
      assign use_word = 1'b0;
    end
  endgenerate

  always_comb begin
    if (funct3_m_q == 3'b000) begin
      sel_res = ProdM[XLEN-1:0];
    end else begin
      sel_res = ProdM[2*XLEN-1:XLEN];
    end
    // MULW sign-extends the low word whatever the high/low selection says.
    if (use_word) begin
      sel_res = word_ext;
    end
  end

  // Divide encodings (funct3[2]=1) never produce a multiply result.
  assign live_m     = valid_m_q & ~funct3_m_q[2];
  assign MulValidM  = live_m;
  assign MulResultM = live_m ? sel_res : '0;

  always_comb begin
    valid_w_d  = valid_w_q;
    result_w_d = result_w_q;
    if (FlushW) begin
      valid_w_d  = 1'b0;
      result_w_d = '0;
    end else if (!StallW) begin
      if (StallM) begin
        // M is holding its op for another cycle; pass a bubble so the
        // same result is not written back twice.
        valid_w_d  = 1'b0;
        result_w_d = '0;
      end else begin
        valid_w_d  = MulValidM;
        result_w_d = MulResultM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_w_q  <= 1'b0;
      result_w_q <= '0;
    end else begin
      valid_w_q  <= valid_w_d;
      result_w_q <= result_w_d;
    end
  end

  assign MulValidW  = valid_w_q;
  assign MulResultW = result_w_q;

endmodule

// File: tb/tb_mul_result.sv
// Directed bench for mul_result (XLEN=64) with hand-computed expected values.
module tb_mul_result;

  localparam int XLEN = 64;

  logic              clk;
  logic              reset;
  logic              StallM, FlushM, StallW, FlushW;
  logic              MulValidE;
  logic [2:0]        Funct3E;
  logic              W64E;
  logic [2*XLEN-1:0] ProdM;
  logic [XLEN-1:0]   MulResultM, MulResultW;
  logic              MulValidM, MulValidW;

  int n_checks;
  int n_fail;

  mul_result #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .StallM     (StallM),
    .FlushM     (FlushM),
    .StallW     (StallW),
    .FlushW     (FlushW),
    .MulValidE  (MulValidE),
    .Funct3E    (Funct3E),
    .W64E       (W64E),
    .ProdM      (ProdM),
    .MulResultM (MulResultM),
    .MulValidM  (MulValidM),
    .MulResultW (MulResultW),
    .MulValidW  (MulValidW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    StallM    = 1'b0;
    FlushM    = 1'b0;
    StallW    = 1'b0;
    FlushW    = 1'b0;
    MulValidE = 1'b0;
    Funct3E   = 3'b000;
    W64E      = 1'b0;
    ProdM     = '0;

    // Reset state
    step();
    step();
    check("rst_resM", MulResultM, 64'h0);
    check("rst_vldM", MulValidM, 64'h0);
    check("rst_resW", MulResultW, 64'h0);
    check("rst_vldW", MulValidW, 64'h0);
    reset = 1'b0;

    // MULH: high half of product
    MulValidE = 1'b1; Funct3E = 3'b001; W64E = 1'b0;
    step();
    MulValidE = 1'b0; Funct3E = 3'b000;
    ProdM = {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    #1;
    check("mulh_resM", MulResultM, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mulh_vldM", MulValidM, 64'h1);
    step();
    check("mulh_resW", MulResultW, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mulh_vldW", MulValidW, 64'h1);
    check("idle_vldM", MulValidM, 64'h0);
    check("idle_resM", MulResultM, 64'h0);

    // Back-to-back MULW, MUL, MULHU
    MulValidE = 1'b1; Funct3E = 3'b000; W64E = 1'b1;
    step();
    ProdM = {64'hDEAD_BEEF_0000_0001, 64'h0000_0000_8000_0000};
    W64E = 1'b0;
    #1;
    check("mulw_resM", MulResultM, 64'hFFFF_FFFF_8000_0000);
    step();
    check("mulw_resW", MulResultW, 64'hFFFF_FFFF_8000_0000);
    check("mulw_vldW", MulValidW, 64'h1);
    check("mul_resM", MulResultM, 64'h0000_0000_8000_0000);
    Funct3E = 3'b011;
    step();
    check("mul_resW", MulResultW, 64'h0000_0000_8000_0000);
    check("mul_vldW", MulValidW, 64'h1);
    check("mulhu_resM", MulResultM, 64'hDEAD_BEEF_0000_0001);
    MulValidE = 1'b0; Funct3E = 3'b000;
    step();
    check("mulhu_resW", MulResultW, 64'hDEAD_BEEF_0000_0001);
    check("mulhu_vldW", MulValidW, 64'h1);
    step();
    check("b2b_end_vldW", MulValidW, 64'h0);

    // StallM without StallW: one bubble, then a single writeback
    MulValidE = 1'b1; Funct3E = 3'b001;
    step();
    MulValidE = 1'b0; Funct3E = 3'b000;
    ProdM = {64'h0000_0000_0000_0042, 64'h0};
    StallM = 1'b1;
    #1;
    check("stm_resM", MulResultM, 64'h42);
    step();
    check("stm_bubble_vldW", MulValidW, 64'h0);
    check("stm_hold_vldM", MulValidM, 64'h1);
    StallM = 1'b0;
    step();
    check("stm_resW", MulResultW, 64'h42);
    check("stm_vldW", MulValidW, 64'h1);
    step();
    check("stm_nodup_vldW", MulValidW, 64'h0);

    // StallW held two cycles after a result reaches W
    MulValidE = 1'b1; Funct3E = 3'b000;
    step();
    ProdM = {64'h0, 64'h0000_0000_0000_00A1};
    Funct3E = 3'b001;
    step();
    ProdM = {64'h0000_0000_0000_00B2, 64'hFFFF_FFFF_FFFF_FFFF};
    MulValidE = 1'b0; Funct3E = 3'b000;
    StallM = 1'b1; StallW = 1'b1;
    #1;
    check("stw0_resW", MulResultW, 64'hA1);
    check("stw_resM", MulResultM, 64'hB2);
    step();
    check("stw1_resW", MulResultW, 64'hA1);
    check("stw1_vldW", MulValidW, 64'h1);
    step();
    check("stw2_resW", MulResultW, 64'hA1);
    check("stw2_vldW", MulValidW, 64'h1);
    StallM = 1'b0; StallW = 1'b0;
    step();
    check("stw_rel_resW", MulResultW, 64'hB2);
    check("stw_rel_vldW", MulValidW, 64'h1);

    // FlushM with StallM and StallW: M clears, W holds
    StallW = 1'b1; MulValidE = 1'b1; Funct3E = 3'b000;
    step();
    ProdM = {64'h0, 64'h0000_0000_0000_0077};
    #1;
    check("flm_pre_resM", MulResultM, 64'h77);
    FlushM = 1'b1; StallM = 1'b1;
    step();
    check("flm_vldM", MulValidM, 64'h0);
    check("flm_resM", MulResultM, 64'h0);
    check("flm_hold_resW", MulResultW, 64'hB2);
    check("flm_hold_vldW", MulValidW, 64'h1);
    FlushM = 1'b0; StallM = 1'b0; StallW = 1'b0; MulValidE = 1'b0;
    step();
    check("flm_after_vldW", MulValidW, 64'h0);

    // Divide encoding is never a live multiply
    MulValidE = 1'b1; Funct3E = 3'b100;
    step();
    ProdM = {128{1'b1}};
    MulValidE = 1'b0; Funct3E = 3'b000;
    #1;
    check("div_vldM", MulValidM, 64'h0);
    check("div_resM", MulResultM, 64'h0);
    step();
    check("div_vldW", MulValidW, 64'h0);
    check("div_resW", MulResultW, 64'h0);

    // MULW ignores Funct3 (high select) and sign-extends a positive word
    MulValidE = 1'b1; Funct3E = 3'b001; W64E = 1'b1;
    step();
    ProdM = {64'hAAAA_AAAA_AAAA_AAAA, 64'h1234_5678_7FFF_FFFF};
    MulValidE = 1'b0; Funct3E = 3'b000; W64E = 1'b0;
    #1;
    check("mulwh_resM", MulResultM, 64'h0000_0000_7FFF_FFFF);
    step();
    check("mulwh_resW", MulResultW, 64'h0000_0000_7FFF_FFFF);

    // FlushW beats StallW
    StallW = 1'b1; FlushW = 1'b1;
    step();
    check("flw_vldW", MulValidW, 64'h0);
    check("flw_resW", MulResultW, 64'h0);
    StallW = 1'b0; FlushW = 1'b0;

    // Reset with live ops in M and W, overriding stalls
    MulValidE = 1'b1; Funct3E = 3'b000; W64E = 1'b0;
    ProdM = {64'h0, 64'h0000_0000_0000_0055};
    step();
    step();
    check("prerst_vldM", MulValidM, 64'h1);
    check("prerst_vldW", MulValidW, 64'h1);
    reset = 1'b1; StallM = 1'b1; StallW = 1'b1;
    step();
    check("rst2_resM", MulResultM, 64'h0);
    check("rst2_vldM", MulValidM, 64'h0);
    check("rst2_resW", MulResultW, 64'h0);
    check("rst2_vldW", MulValidW, 64'h0);
    reset = 1'b0; StallM = 1'b0; StallW = 1'b0;
    step();
    ProdM = {64'h0, 64'h0000_0000_0000_0099};
    MulValidE = 1'b0;
    #1;
    check("postrst_resM", MulResultM, 64'h99);
    check("postrst_vldM", MulValidM, 64'h1);
    check("postrst_early_vldW", MulValidW, 64'h0);
    step();
    check("postrst_resW", MulResultW, 64'h99);
    check("postrst_vldW", MulValidW, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_result.md
MUL_RESULT -- requirements
Module: mul_result

Interface
REQ-001 Parameter: XLEN, default 64, integer register width; legal values 32 and 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 StallM  input  1  hold E->M pipeline register.
REQ-005 FlushM  input  1  clear E->M pipeline register.
REQ-006 StallW  input  1  hold M->W pipeline register.
REQ-007 FlushW  input  1  clear M->W pipeline register.
REQ-008 MulValidE  input  1  a multiply instruction occupies the Execute stage.
REQ-009 Funct3E  input  3  multiply type: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-010 W64E  input  1  word-width operation (MULW); meaningful only when XLEN=64.
REQ-011 ProdM  input  2*XLEN  registered double-width product from the multiplier, valid in M.
REQ-012 MulResultM  output  XLEN  selected result in M, for forwarding.
REQ-013 MulValidM  output  1  MulResultM holds a live multiply result.
REQ-014 MulResultW  output  XLEN  registered result in Writeback.
REQ-015 MulValidW  output  1  MulResultW holds a live multiply result.

Function
REQ-016 The E->M register SHALL capture {MulValidE, Funct3E, W64E} when ~StallM, hold when StallM, and load all zeros when FlushM.
REQ-017 FlushM SHALL take priority over StallM; FlushW SHALL take priority over StallW.
REQ-018 Selection in M SHALL be: Funct3M=000 -> ProdM[XLEN-1:0]; 001/010/011 -> ProdM[2*XLEN-1:XLEN].
REQ-019 When XLEN=64 and W64M=1, MulResultM SHALL be ProdM[31:0] sign-extended from bit 31, regardless of Funct3M.
REQ-020 When XLEN=32, W64M SHALL be ignored.
REQ-021 Funct3M in 100..111 (divide encodings) SHALL force MulResultM=0 and MulValidM=0.
REQ-022 When MulValidM=0, MulResultM SHALL be 0.
REQ-023 The M->W register SHALL capture {MulValidM, MulResultM} when ~StallW, hold when StallW, and load zeros when FlushW.
REQ-024 Latency: an op accepted in E at edge n SHALL appear on MulResultM/MulValidM after edge n and on MulResultW/MulValidW after edge n+1, absent stalls.
REQ-025 A stall in M with no stall in W SHALL NOT duplicate a result: the block SHALL accept an external StallW=1 whenever StallM=1, and SHALL produce MulValidW=0 on the edge following any cycle with StallM=1 and StallW=0.
REQ-026 Back-to-back valid ops on consecutive cycles SHALL each produce one MulValidW pulse carrying its own result, in order.
REQ-027 Simultaneous FlushM and StallW SHALL clear M while W holds its value.

Reset
REQ-028 On reset=1 at a rising edge, all pipeline state SHALL clear: MulValidM=0, MulResultM=0, MulValidW=0, MulResultW=0.
REQ-029 Reset SHALL override stall and flush inputs and SHALL discard any in-flight operation; the first edge with reset=0 resumes normal capture.

Verification (XLEN=64)
REQ-030 MULH: Funct3E=001, MulValidE=1, then ProdM={64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000} -> MulResultM=64'hFFFF_FFFF_FFFF_FFFF, MulValidM=1; next edge MulResultW equal, MulValidW=1.
REQ-031 MULW: W64E=1, Funct3E=000, ProdM low=64'h0000_0000_8000_0000 -> MulResultM=64'hFFFF_FFFF_8000_0000; MUL with same ProdM and W64E=0 -> 64'h0000_0000_8000_0000.
REQ-032 StallW held 2 cycles after a valid result reaches W -> MulResultW and MulValidW unchanged for both cycles; release -> next M result loads.
REQ-033 FlushM asserted together with StallM and MulValidE=1 -> MulValidM=0, MulResultM=0 next cycle; the W stage is unaffected.
REQ-034 Funct3E=100 with MulValidE=1 -> MulValidM=0, MulResultM=0 regardless of ProdM.
REQ-035 reset asserted with valid ops in both M and W -> after one edge all four outputs are 0; first op after deassertion completes with normal 2-edge latency.
